leitor_caminho_anterior: RTL and testbench

// Back end of the path search. Once the search core reports completion, this block walks the

---
 rtl/leitor_caminho_anterior.sv | 189 ++++++++++++++++++
 tb/tb_leitor_caminho_anterior.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_caminho_anterior.sv
// leitor_caminho_anterior
// Back end of the path search. After the search core finishes, this block walks the predecessor
// (anterior) memory from DESTINO back to FONTE and pushes every visited node onto an internal
// LIFO. It then streams the path in forward order (FONTE first, DESTINO last) over valid/ready.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous reset, active-high (legacy name kept from the codebase)
//   start_in             1-cycle start pulse, ignored unless idle
//   fonte_in/destino_in  source/destination nodes, sampled on an accepted start
//   ant_rd_en_out        anterior memory read strobe (only in BUSCA)
//   ant_rd_addr_out      anterior memory read address
//   ant_rd_data_in       predecessor of the addressed node, valid 1 cycle after the strobe
//   caminho_valid_out    path word valid
//   caminho_addr_out     path node
//   caminho_last_out     marks the DESTINO word
//   caminho_ready_in     downstream accepts the word on valid && ready
//   caminho_tamanho_out  number of nodes in the path, set on entry to EMITIR
//   busy_out             FSM not idle
//   pronto_out           1-cycle pulse after the last word is accepted
//   erro_out             sticky until next accepted start: path longer than MAX_CAMINHO
module leitor_caminho_anterior #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned MAX_CAMINHO = 64,
  parameter int unsigned CNT_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  ant_rd_en_out,
  output logic [ADDR_WIDTH-1:0] ant_rd_addr_out,
  input  logic [ADDR_WIDTH-1:0] ant_rd_data_in,
  output logic                  caminho_valid_out,
  output logic [ADDR_WIDTH-1:0] caminho_addr_out,
  output logic                  caminho_last_out,
  input  logic                  caminho_ready_in,
  output logic [CNT_WIDTH-1:0]  caminho_tamanho_out,
  output logic                  busy_out,
  output logic                  pronto_out,
  output logic                  erro_out
);

  localparam int unsigned PtrW = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(MAX_CAMINHO);

  typedef enum logic [1:0] {
    StIdle,
    StBusca,
    StEspera,
    StEmitir
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [ADDR_WIDTH-1:0] r_fonte;
  logic [ADDR_WIDTH-1:0] r_atual;
  // r_cnt is both the LIFO fill level and, while walking, the path length so far.
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_tamanho;
  logic                  r_pronto;
  logic                  r_erro;
  logic [ADDR_WIDTH-1:0] r_lifo [MAX_CAMINHO];

  logic                  w_start;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_emit_entry;
  logic                  w_set_erro;
  logic                  w_last;
  logic [PtrW-1:0]       w_push_idx;
  logic [PtrW-1:0]       w_top_idx;

  assign w_push_idx = r_cnt[PtrW-1:0];
  assign w_top_idx  = w_push_idx - PtrW'(1);
  assign w_last     = (r_cnt == CntOne);

  assign busy_out            = (r_state != StIdle);
  assign pronto_out          = r_pronto;
  assign erro_out            = r_erro;
  assign caminho_tamanho_out = r_tamanho;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d         = r_state;
    w_start           = 1'b0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_emit_entry      = 1'b0;
    w_set_erro        = 1'b0;
    ant_rd_en_out     = 1'b0;
    ant_rd_addr_out   = '0;
    caminho_valid_out = 1'b0;
    caminho_addr_out  = '0;
    caminho_last_out  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_in) begin
          w_start   = 1'b1;
          w_state_d = StBusca;
        end
      end
      StBusca: begin
        if (r_atual == r_fonte) begin
          w_emit_entry = 1'b1;
          w_state_d    = StEmitir;
        end else begin
          ant_rd_en_out   = 1'b1;
          ant_rd_addr_out = r_atual;
          w_state_d       = StEspera;
        end
      end
      StEspera: begin
        // A full LIFO is an error even if this read returns FONTE: it would need one more slot.
        if (r_cnt == CntMax) begin
          w_set_erro = 1'b1;
          w_state_d  = StIdle;
        end else begin
          w_push    = 1'b1;
          w_state_d = StBusca;
        end
      end
      StEmitir: begin
        caminho_valid_out = 1'b1;
        caminho_addr_out  = r_lifo[w_top_idx];
        caminho_last_out  = w_last;
        if (caminho_ready_in) begin
          w_pop = 1'b1;
          if (w_last) begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_fonte   <= '0;
      r_atual   <= '0;
      r_cnt     <= '0;
      r_tamanho <= '0;
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_pronto <= w_pop && w_last;
      if (w_start) begin
        r_fonte   <= fonte_in;
        r_atual   <= destino_in;
        r_cnt     <= CntOne;
        r_erro    <= 1'b0;
        r_tamanho <= '0;
      end
      if (w_push) begin
        r_atual <= ant_rd_data_in;
        r_cnt   <= r_cnt + CntOne;
      end
      if (w_pop) begin
        r_cnt <= r_cnt - CntOne;
      end
      if (w_set_erro) begin
        r_erro <= 1'b1;
      end
      if (w_emit_entry) begin
        r_tamanho <= r_cnt;
      end
    end
  end

  // Storage needs no reset: an empty LIFO is defined by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_lifo[0] <= destino_in;
    end else if (w_push) begin
      r_lifo[w_push_idx] <= ant_rd_data_in;
    end
  end

endmodule

// File: tb/tb_leitor_caminho_anterior.sv
module tb_leitor_caminho_anterior;

  localparam int AW  = 6;
  localparam int MAX = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_in = 1'b0;
  logic [AW-1:0] fonte_in = '0;
  logic [AW-1:0] destino_in = '0;
  logic          ant_rd_en_out;
  logic [AW-1:0] ant_rd_addr_out;
  logic [AW-1:0] ant_rd_data_in = '0;
  logic          caminho_valid_out;
  logic [AW-1:0] caminho_addr_out;
  logic          caminho_last_out;
  logic          caminho_ready_in = 1'b0;
  logic [CW-1:0] caminho_tamanho_out;
  logic          busy_out;
  logic          pronto_out;
  logic          erro_out;

  leitor_caminho_anterior #(
    .ADDR_WIDTH (AW),
    .MAX_CAMINHO(MAX),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_in           (start_in),
    .fonte_in           (fonte_in),
    .destino_in         (destino_in),
    .ant_rd_en_out      (ant_rd_en_out),
    .ant_rd_addr_out    (ant_rd_addr_out),
    .ant_rd_data_in     (ant_rd_data_in),
    .caminho_valid_out  (caminho_valid_out),
    .caminho_addr_out   (caminho_addr_out),
    .caminho_last_out   (caminho_last_out),
    .caminho_ready_in   (caminho_ready_in),
    .caminho_tamanho_out(caminho_tamanho_out),
    .busy_out           (busy_out),
    .pronto_out         (pronto_out),
    .erro_out           (erro_out)
  );

  always #5 clk = ~clk;

  // Anterior memory: synchronous read, data one cycle after the strobe.
  logic [AW-1:0] ant_mem [64];
  always @(posedge clk) begin
    if (ant_rd_en_out) ant_rd_data_in <= ant_mem[ant_rd_addr_out];
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: follow predecessors from DESTINO, prepending each node; the path may hold
  // at most MAX nodes, so a read made with MAX nodes already held ends in error.
  int  exp_path[$];
  int  exp_reads[$];
  bit  exp_err;

  task automatic model(input int f, input int d);
    int cur;
    exp_path.delete();
    exp_reads.delete();
    exp_err = 1'b0;
    cur = d;
    exp_path.push_front(d);
    while (cur != f) begin
      exp_reads.push_back(cur);
      if (exp_path.size() == MAX) begin
        exp_err = 1'b1;
        break;
      end
      cur = int'(ant_mem[cur]);
      exp_path.push_front(cur);
    end
    if (exp_err) exp_path.delete();
  endtask

  bit toggle_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Runs one reconstruction from a negedge; mode 0: ready=1, 1: toggle pattern, 2: random.
  task automatic run_path(input int f, input int d, input int mode, input bit inject,
                          output int o_tam, output int o_err, output int o_first);
    int  got_path[$];
    int  got_last[$];
    int  got_reads[$];
    int  c, k, first_valid, last_acc, pronto_cycle, prev_addr, n_exp;
    bit  done, got_err, prev_hold, injected;
    model(f, d);
    got_err = 0; first_valid = -1; last_acc = -1; pronto_cycle = -1;
    prev_hold = 0; prev_addr = 0; injected = 0; k = 0; done = 0;
    fonte_in   = AW'(f);
    destino_in = AW'(d);
    start_in   = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    c = 1;
    while (!done && c <= 400) begin
      if (injected) start_in = 1'b0;
      if (ant_rd_en_out) got_reads.push_back(int'(ant_rd_addr_out));
      if (pronto_out) pronto_cycle = c;
      if (erro_out) got_err = 1'b1;
      if (prev_hold) begin
        chk("hold_valid", int'(caminho_valid_out), 1);
        chk("hold_addr", int'(caminho_addr_out), prev_addr);
      end
      if (!busy_out) begin
        done = 1'b1;
      end else begin
        case (mode)
          0:       caminho_ready_in = 1'b1;
          1:       caminho_ready_in = toggle_pat[k % 6];
          default: caminho_ready_in = 1'($urandom_range(0, 1));
        endcase
        k++;
        if (caminho_valid_out) begin
          if (first_valid < 0) begin
            first_valid = c;
            chk("tamanho_on_emit", int'(caminho_tamanho_out), exp_path.size());
            if (inject) begin
              fonte_in   = 6'd7;
              destino_in = 6'd7;
              start_in   = 1'b1;
              injected   = 1'b1;
            end
          end
          if (caminho_ready_in) begin
            got_path.push_back(int'(caminho_addr_out));
            got_last.push_back(int'(caminho_last_out));
            last_acc = c;
          end
        end
        prev_hold = caminho_valid_out && !caminho_ready_in;
        prev_addr = int'(caminho_addr_out);
        @(negedge clk);
        c++;
      end
    end
    start_in = 1'b0;
    if (!done) chk("timeout", 0, 1);
    n_exp = exp_path.size();
    chk("erro", int'(got_err), int'(exp_err));
    chk("erro_sticky", int'(erro_out), int'(exp_err));
    chk("path_len", got_path.size(), n_exp);
    for (int i = 0; i < got_path.size() && i < n_exp; i++) begin
      chk("path_word", got_path[i], exp_path[i]);
      chk("last_flag", got_last[i], int'(i == n_exp - 1));
    end
    chk("read_count", got_reads.size(), exp_reads.size());
    for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++) begin
      chk("read_addr", got_reads[i], exp_reads[i]);
    end
    if (exp_err) begin
      chk("no_valid_on_err", first_valid, -1);
      chk("no_pronto_on_err", pronto_cycle, -1);
    end else begin
      chk("latency", first_valid, 2 * (n_exp - 1) + 2);
      chk("pronto_timing", pronto_cycle, last_acc + 1);
    end
    chk("busy_after", int'(busy_out), 0);
    o_tam   = int'(caminho_tamanho_out);
    o_err   = int'(got_err);
    o_first = (got_path.size() > 0) ? got_path[0] : -1;
  endtask

  typedef struct {
    int f;
    int d;
    int mode;
    int exp_tam;
    int exp_err;
    int exp_first;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   tam, err, first;
    int   nodes[$];
    bit   used[64];
    int   len, n;

    for (int i = 0; i < 64; i++) ant_mem[i] = AW'(i);
    ant_mem[5] = 6'd3; ant_mem[3] = 6'd1; ant_mem[1] = 6'd0;
    ant_mem[4] = 6'd2; ant_mem[2] = 6'd4;

    vecs.push_back('{0, 5, 0, 4, 0, 0});  // chain 5->3->1->0
    vecs.push_back('{7, 7, 0, 1, 0, 7});  // fonte == destino
    vecs.push_back('{0, 4, 0, 0, 1, -1}); // predecessor loop
    vecs.push_back('{0, 5, 1, 4, 0, 0});  // toggling ready
    vecs.push_back('{1, 5, 0, 3, 0, 1});
    vecs.push_back('{3, 5, 2, 2, 0, 3});

    // Reset held: all outputs low.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_valid", int'(caminho_valid_out), 0);
    chk("rst_rd_en", int'(ant_rd_en_out), 0);
    chk("rst_outs", int'({pronto_out, erro_out, caminho_last_out}), 0);
    chk("rst_tamanho", int'(caminho_tamanho_out), 0);
    rst_n = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_path(vecs[i].f, vecs[i].d, vecs[i].mode, 1'b0, tam, err, first);
      chk("vec_tamanho", tam, vecs[i].exp_tam);
      chk("vec_erro", err, vecs[i].exp_err);
      chk("vec_first", first, vecs[i].exp_first);
      @(negedge clk);
    end

    // Start pulse during EMITIR is ignored; a new start right after completion works.
    run_path(0, 5, 1, 1'b1, tam, err, first);
    chk("inject_tamanho", tam, 4);
    run_path(7, 7, 0, 1'b0, tam, err, first);
    chk("after_inject_tamanho", tam, 1);

    // Asynchronous reset in the middle of BUSCA.
    caminho_ready_in = 1'b1;
    fonte_in = 6'd0; destino_in = 6'd5; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("pre_rst_rd_en", int'(ant_rd_en_out), 1);
    #2 rst_n = 1'b1;
    #1;
    chk("midrst_busy", int'(busy_out), 0);
    chk("midrst_rd_en", int'(ant_rd_en_out), 0);
    chk("midrst_valid", int'(caminho_valid_out), 0);
    chk("midrst_outs", int'({pronto_out, erro_out, caminho_tamanho_out}), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("postrst_busy", int'(busy_out), 0);
    chk("postrst_valid", int'(caminho_valid_out), 0);
    run_path(0, 5, 0, 1'b0, tam, err, first);
    chk("postrst_tamanho", tam, 4);

    // Randomized chains checked against the model.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 64; i++) begin
        ant_mem[i] = AW'($urandom_range(0, 63));
        used[i] = 1'b0;
      end
      nodes.delete();
      len = $urandom_range(1, MAX + 2);
      while (nodes.size() < len) begin
        n = $urandom_range(0, 63);
        if (!used[n]) begin
          used[n] = 1'b1;
          nodes.push_back(n);
        end
      end
      for (int i = 1; i < len; i++) ant_mem[nodes[i]] = AW'(nodes[i - 1]);
      if (it % 5 == 4) nodes[0] = $urandom_range(0, 63);
      run_path(nodes[0], nodes[len - 1], 2, 1'b0, tam, err, first);
      chk("rnd_tamanho", tam, exp_err ? 0 : exp_path.size());
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
